// File: rtl/prei_mode_sel.sv
// prei_mode_sel: per-8x8-block amplitude-weighted angular histogram and best-intra-mode picker.
// Optional PREI_MODE_SEL_SECOND_EN adds mode2_o, the second-best angular bin.
module prei_mode_sel #(
  parameter int AMP_W   = 8,
  parameter int ACC_W   = 14,
  parameter int SUM_W   = 20,
  parameter int FLAT_TH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             acc_en_i,
  input  logic [5:0]       mode_i,
  input  logic [AMP_W-1:0] amp_i,
  input  logic             newblock_i,
  input  logic [6:0]       blockcnt_i,
  input  logic             finish_i,
  output logic             valid_o,
  output logic [5:0]       mode_o,
  output logic [5:0]       blk_idx_o,
  output logic             busy_o,
`ifdef PREI_MODE_SEL_SECOND_EN
  output logic [5:0]       mode2_o,
  output logic             ovf_o
`else
  output logic             ovf_o
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] bank_a [2:34];
  logic [ACC_W-1:0] bank_b [2:34];
  logic [ACC_W-1:0] a_nxt [2:34];
  logic [SUM_W-1:0] sum, sum_nxt, b_sum;
  logic [ACC_W:0]   bin_add;
  logic [SUM_W:0]   sum_add;
  logic [6:0]       idx;
  logic [5:0]       mode_sel, scan_idx, blk_cur, best_mode, nb_mode;
  logic [ACC_W-1:0] cur, best_val, nb_val;
  logic             mode_ok, close_ok, gt_best, is_dc;
  assign mode_ok  = acc_en_i && mode_i >= 6'd2 && mode_i <= 6'd34;
  assign mode_sel = mode_ok ? mode_i : 6'd2;
  assign bin_add  = {1'b0, bank_a[mode_sel]} + (ACC_W+1)'(amp_i);
  assign sum_add  = {1'b0, sum} + (SUM_W+1)'(amp_i);
  assign idx      = blockcnt_i - 7'd1;
  assign close_ok = newblock_i && !idx[6];
  always_comb begin
    a_nxt   = bank_a;
    sum_nxt = sum;
    if (mode_ok) begin
      a_nxt[mode_sel] = bin_add[ACC_W] ? '1 : bin_add[ACC_W-1:0];
      sum_nxt         = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
    end
  end
  // strict greater-than keeps the lowest mode index on ties
  assign cur     = bank_b[scan_idx];
  assign gt_best = cur > best_val;
  assign nb_val  = gt_best ? cur : best_val;
  assign nb_mode = gt_best ? scan_idx : best_mode;
  assign is_dc   = b_sum < SUM_W'(FLAT_TH);
`ifdef PREI_MODE_SEL_SECOND_EN
  logic [ACC_W-1:0] sec_val, ns_val;
  logic [5:0]       sec_mode, ns_mode;
  logic             gt_sec;
  assign gt_sec  = cur > sec_val;
  assign ns_val  = gt_best ? best_val : gt_sec ? cur : sec_val;
  assign ns_mode = gt_best ? best_mode : gt_sec ? scan_idx : sec_mode;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = finish_i ? IDLE :
                close_ok ? SCAN :
                (state == SCAN && scan_idx != 6'd34) ? SCAN :
                (state == SCAN) ? EMIT : IDLE;
  end
  always_comb begin
    busy_o  = state != IDLE;
    valid_o = state == EMIT;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_a    <= '{default: '0};
      bank_b    <= '{default: '0};
      sum       <= '0;
      b_sum     <= '0;
      scan_idx  <= 6'd2;
      blk_cur   <= '0;
      best_val  <= '0;
      best_mode <= 6'd2;
      mode_o    <= '0;
      blk_idx_o <= '0;
      ovf_o     <= 1'b0;
`ifdef PREI_MODE_SEL_SECOND_EN
      sec_val   <= '0;
      sec_mode  <= 6'd2;
      mode2_o   <= '0;
`endif
    end else if (finish_i) begin
      bank_a <= '{default: '0};
      bank_b <= '{default: '0};
      sum    <= '0;
      b_sum  <= '0;
    end else if (close_ok) begin
      bank_a    <= '{default: '0};
      sum       <= '0;
      bank_b    <= a_nxt;
      b_sum     <= sum_nxt;
      blk_cur   <= idx[5:0];
      scan_idx  <= 6'd2;
      best_val  <= '0;
      best_mode <= 6'd2;
      if (busy_o) ovf_o <= 1'b1;
`ifdef PREI_MODE_SEL_SECOND_EN
      sec_val   <= '0;
      sec_mode  <= 6'd2;
`endif
    end else begin
      bank_a <= newblock_i ? '{default: '0} : a_nxt;
      sum    <= newblock_i ? '0 : sum_nxt;
      if (state == SCAN) begin
        best_val  <= nb_val;
        best_mode <= nb_mode;
`ifdef PREI_MODE_SEL_SECOND_EN
        sec_val   <= ns_val;
        sec_mode  <= ns_mode;
`endif
        if (scan_idx == 6'd34) begin
          mode_o    <= is_dc ? 6'd1 : nb_mode;
          blk_idx_o <= blk_cur;
`ifdef PREI_MODE_SEL_SECOND_EN
          mode2_o   <= is_dc ? 6'd2 : ns_mode;
`endif
        end else begin
          scan_idx <= scan_idx + 6'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_prei_mode_sel.sv
// tb_prei_mode_sel: directed self-checking bench for prei_mode_sel.
module tb_prei_mode_sel;
  logic clk = 0, rstn = 0, acc_en_i = 0, newblock_i = 0, finish_i = 0;
  logic [5:0] mode_i = 0;
  logic [7:0] amp_i = 0;
  logic [6:0] blockcnt_i = 0;
  logic valid_o, busy_o, ovf_o;
  logic [5:0] mode_o, blk_idx_o;
`ifdef PREI_MODE_SEL_SECOND_EN
  logic [5:0] mode2_o;
`endif
  int errs = 0, checks = 0;
  prei_mode_sel dut (
    .clk(clk), .rstn(rstn), .acc_en_i(acc_en_i), .mode_i(mode_i), .amp_i(amp_i),
    .newblock_i(newblock_i), .blockcnt_i(blockcnt_i), .finish_i(finish_i),
    .valid_o(valid_o), .mode_o(mode_o), .blk_idx_o(blk_idx_o), .busy_o(busy_o),
`ifdef PREI_MODE_SEL_SECOND_EN
    .mode2_o(mode2_o),
`endif
    .ovf_o(ovf_o)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic vote(input int m, input int a, input int n);
    acc_en_i = 1;
    mode_i = 6'(m);
    amp_i = 8'(a);
    repeat (n) step();
    acc_en_i = 0;
  endtask
  task automatic close(input int bc);
    newblock_i = 1;
    blockcnt_i = 7'(bc);
    step();
    newblock_i = 0;
  endtask
  task automatic close_wait(input int bc, output int lat);
    close(bc);
    lat = 1;
    while (!valid_o && lat < 60) begin
      step();
      lat++;
    end
  endtask
  task automatic test_reset;
    repeat (2) step();
    checks++; if (valid_o !== 0) begin errs++; $display("FAIL reset_valid got %0d want 0", valid_o); end
    checks++; if (busy_o !== 0) begin errs++; $display("FAIL reset_busy got %0d want 0", busy_o); end
    checks++; if ({mode_o, blk_idx_o, ovf_o} !== 13'd0) begin errs++; $display("FAIL reset_outs got mode=%0d idx=%0d ovf=%0d want 0", mode_o, blk_idx_o, ovf_o); end
    rstn = 1;
    step();
  endtask
  task automatic test_basic;
    int lat;
    vote(26, 20, 10);
    close_wait(1, lat);
    checks++; if (lat !== 34) begin errs++; $display("FAIL basic_latency got %0d want 34", lat); end
    checks++; if (mode_o !== 6'd26) begin errs++; $display("FAIL basic_mode got %0d want 26", mode_o); end
    checks++; if (blk_idx_o !== 6'd0) begin errs++; $display("FAIL basic_idx got %0d want 0", blk_idx_o); end
    step();
    checks++; if ({valid_o, busy_o} !== 2'b00) begin errs++; $display("FAIL basic_after got valid=%0d busy=%0d want 0 0", valid_o, busy_o); end
    checks++; if (mode_o !== 6'd26) begin errs++; $display("FAIL basic_hold got %0d want 26", mode_o); end
    checks++; if (ovf_o !== 0) begin errs++; $display("FAIL basic_ovf got %0d want 0", ovf_o); end
  endtask
  task automatic test_flat;
    int lat;
    vote(5, 30, 1); vote(18, 33, 1);
    close_wait(2, lat);
    checks++; if (mode_o !== 6'd1 || lat !== 34) begin errs++; $display("FAIL flat63 got mode=%0d lat=%0d want 1 34", mode_o, lat); end
    vote(5, 30, 1); vote(18, 34, 1);
    close_wait(3, lat);
    checks++; if (mode_o !== 6'd18 || blk_idx_o !== 6'd2) begin errs++; $display("FAIL flat64 got mode=%0d idx=%0d want 18 2", mode_o, blk_idx_o); end
    vote(0, 200, 1); vote(40, 200, 1); vote(12, 60, 1);
    close_wait(4, lat);
    checks++; if (mode_o !== 6'd1) begin errs++; $display("FAIL bad_mode_ignored got %0d want 1", mode_o); end
  endtask
  task automatic test_tie_sat;
    int lat;
    vote(10, 250, 4); vote(30, 250, 4);
    close_wait(1, lat);
    checks++; if (mode_o !== 6'd10) begin errs++; $display("FAIL tie got %0d want 10", mode_o); end
    vote(2, 255, 100); vote(3, 255, 64); vote(3, 63, 1);
    close_wait(1, lat);
    checks++; if (mode_o !== 6'd2) begin errs++; $display("FAIL saturate got %0d want 2", mode_o); end
  endtask
  task automatic test_index;
    int lat;
    int seen = 0;
    close(65);
    repeat (40) begin step(); if (valid_o || busy_o) seen = 1; end
    checks++; if (seen !== 0) begin errs++; $display("FAIL idx65_no_scan got %0d want 0", seen); end
    vote(34, 100, 1);
    close_wait(64, lat);
    checks++; if (blk_idx_o !== 6'd63 || mode_o !== 6'd34 || lat !== 34) begin errs++; $display("FAIL idx64 got idx=%0d mode=%0d lat=%0d want 63 34 34", blk_idx_o, mode_o, lat); end
  endtask
  task automatic test_overrun;
    int lat;
    int seen = 0;
    vote(15, 100, 1);
    close(5);
    vote(28, 100, 5);
    repeat (14) begin step(); if (valid_o) seen = 1; end
    checks++; if (seen !== 0 || busy_o !== 1) begin errs++; $display("FAIL ovr_pre got valid_seen=%0d busy=%0d want 0 1", seen, busy_o); end
    close_wait(6, lat);
    checks++; if (lat !== 34) begin errs++; $display("FAIL ovr_latency got %0d want 34", lat); end
    checks++; if (mode_o !== 6'd28 || blk_idx_o !== 6'd5) begin errs++; $display("FAIL ovr_result got mode=%0d idx=%0d want 28 5", mode_o, blk_idx_o); end
    checks++; if (ovf_o !== 1) begin errs++; $display("FAIL ovr_flag got %0d want 1", ovf_o); end
    step();
  endtask
  task automatic test_abort;
    int lat;
    int seen = 0;
    vote(9, 100, 1);
    close(7);
    vote(9, 200, 3);
    repeat (5) step();
    finish_i = 1; acc_en_i = 1; mode_i = 6'd9; amp_i = 8'd50;
    step();
    finish_i = 0; acc_en_i = 0;
    checks++; if ({valid_o, busy_o} !== 2'b00) begin errs++; $display("FAIL abort_stop got valid=%0d busy=%0d want 0 0", valid_o, busy_o); end
    repeat (40) begin step(); if (valid_o) seen = 1; end
    checks++; if (seen !== 0) begin errs++; $display("FAIL abort_no_valid got %0d want 0", seen); end
    vote(20, 10, 7);
    close_wait(8, lat);
    checks++; if (mode_o !== 6'd20 || blk_idx_o !== 6'd7 || lat !== 34) begin errs++; $display("FAIL abort_clean got mode=%0d idx=%0d lat=%0d want 20 7 34", mode_o, blk_idx_o, lat); end
    checks++; if (ovf_o !== 1) begin errs++; $display("FAIL abort_ovf_kept got %0d want 1", ovf_o); end
  endtask
`ifdef PREI_MODE_SEL_SECOND_EN
  task automatic test_second;
    int lat;
    vote(7, 250, 2); vote(20, 200, 4); vote(33, 200, 3);
    close_wait(10, lat);
    checks++; if (mode_o !== 6'd20 || mode2_o !== 6'd33) begin errs++; $display("FAIL second got mode=%0d mode2=%0d want 20 33", mode_o, mode2_o); end
  endtask
`endif
  task automatic test_reset_mid;
    int seen = 0;
    vote(11, 100, 1);
    close(9);
    repeat (5) step();
    rstn = 0;
    #1;
    checks++; if ({valid_o, busy_o, ovf_o} !== 3'b000 || {mode_o, blk_idx_o} !== 12'd0) begin errs++; $display("FAIL rst_mid got valid=%0d busy=%0d ovf=%0d mode=%0d idx=%0d want 0", valid_o, busy_o, ovf_o, mode_o, blk_idx_o); end
    @(negedge clk);
    rstn = 1;
    repeat (40) begin step(); if (valid_o || busy_o) seen = 1; end
    checks++; if (seen !== 0) begin errs++; $display("FAIL rst_mid_quiet got %0d want 0", seen); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_flat();
    test_tie_sat();
    test_index();
    test_overrun();
    test_abort();
`ifdef PREI_MODE_SEL_SECOND_EN
    test_second();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/prei_mode_sel.md
Name: prei_mode_sel

Overview:
- Downstream consumer of the pre-intra controller's per-block timing (`counterrun2`, `newblock`, `blockcnt`, `finish`).
- Accumulates an amplitude-weighted histogram of gradient angle votes over HEVC angular modes 2..34 for each 8x8 block.
- Scans the closed histogram sequentially and emits one decided intra mode per block: best angular mode, or DC when the block is flat.
- Double-buffered, so accumulation of block N+1 overlaps the scan of block N.

Parameters:
- AMP_W, 8, width of the per-vote gradient amplitude.
- ACC_W, 14, width of each histogram bin; saturating.
- SUM_W, 20, width of the total-amplitude accumulator; saturating.
- FLAT_TH, 64, a total amplitude below this value selects DC (mode 1).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- acc_en_i  in  1  vote valid; driven by controller `counterrun2`
- mode_i  in  6  voted angular mode, valid range 2..34
- amp_i  in  AMP_W  vote weight
- newblock_i  in  1  one-cycle block-close pulse from controller
- blockcnt_i  in  7  controller block counter
- finish_i  in  1  frame/CTU end from controller
- valid_o  out  1  one-cycle result strobe
- mode_o  out  6  decided mode (1 = DC, or 2..34)
- blk_idx_o  out  6  block index 0..63 of the result
- busy_o  out  1  scan in progress
- ovf_o  out  1  sticky overrun flag

Behaviour:
- Reset is asynchronous on rstn low. Every output is 0, both histogram banks and the sum are 0, and the FSM is IDLE.
- Accumulate bank A:
  - On acc_en_i with mode_i in 2..34: bin[mode_i] += amp_i and sum += amp_i, both saturating at all-ones.
  - A mode_i outside 2..34 is ignored, with no error.
- Block close (newblock_i high):
  - Bank A, including any vote presented in the same cycle, is copied to scan bank B together with the sum.
  - Bank A and the sum are cleared for the next cycle.
  - idx = blockcnt_i - 1 (mod 128) is captured.
  - If idx >= 64, the snapshot is discarded and no scan starts.
- FSM states are IDLE, SCAN and EMIT.
  - IDLE -> SCAN on a valid close.
  - SCAN examines one bin per cycle, bins 2..34, over 33 cycles.
    - Running max uses strict greater-than, so ties resolve to the lowest mode index.
    - Initial best is bin 2.
  - SCAN -> EMIT after bin 34.
  - EMIT lasts one cycle, drives the outputs, then returns to IDLE.
- Latency: valid_o is high exactly 34 cycles after the cycle in which newblock_i was sampled high. The block period is 41 cycles, so back-to-back blocks never overlap under nominal timing.
- Decision: mode_o = 1 if snapshot sum < FLAT_TH; otherwise mode_o is the argmax bin. An all-zero histogram gives DC.
- mode_o and blk_idx_o hold their value until the next EMIT.
- busy_o is high in SCAN and EMIT.
- Overrun: a valid close while busy_o is high does the following:
  - The running scan is abandoned and restarted on the new snapshot.
  - The old result is never emitted.
  - ovf_o is set and stays set until reset.
- finish_i has priority over newblock_i and acc_en_i in the same cycle. It does the following:
  - clears bank A, bank B and the sum;
  - aborts any scan, with no valid_o;
  - returns the FSM to IDLE;
  - leaves ovf_o unchanged.
- Reset mid-scan: all state returns to the reset values immediately and no valid_o is produced.

Optional Feature:
- Macro: PREI_MODE_SEL_SECOND_EN.
- When defined:
  - Adds output port mode2_o[5:0], the second-best angular bin, tracked during the same scan.
  - A new strict max demotes the old best to second. Otherwise, strict greater-than against the second updates the second.
  - Tie rule is lowest index.
  - mode2_o is 2 when fewer than two bins are nonzero, and also when the block is DC.
  - Same timing as mode_o.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic vote: acc_en_i for 10 cycles with mode_i=26, amp_i=20, then newblock_i with blockcnt_i=1.
  - Expect valid_o 34 cycles later, mode_o=26, blk_idx_o=0.
- Flat block: votes total amplitude 63 spread over modes 5/18, then close.
  - Expect mode_o=1.
  - Repeat with total 64; expect the argmax mode.
- Tie and saturation: bin 10 and bin 30 both 1000, then close.
  - Expect mode_o=10.
  - Separately drive 100 votes of amp 255 on mode 2; expect bin 2 saturated at 16383 and mode_o=2.
- Index boundary: close with blockcnt_i=65.
  - Expect no valid_o and busy_o staying 0.
  - A close with blockcnt_i=64 gives blk_idx_o=63.
- Overrun: second valid close 20 cycles after the first.
  - Expect a single valid_o 34 cycles after the second close, carrying the second block's result, and ovf_o=1.
- Abort: finish_i asserted mid-scan, in the same cycle as a vote.
  - Expect no valid_o and busy_o=0 next cycle.
  - Expect the next block's histogram to contain no pre-finish votes.
- Feature on: bins 7=500, 20=800, 33=600.
  - Expect mode_o=20, mode2_o=33.
